// File: rtl/lcd_timing_pattern_gen.sv
// RGB-LCD timing generator with internal pixel clock-enable
// and a selectable test-pattern source (bars, grid, gradient, solid).
`timescale 1ns/1ps
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 4,
  parameter int H_BP      = 43,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 8,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 12,
  parameter int PIX_DIV   = 10,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int GRID_LOG2 = 4,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_rgb,
  output logic          pix_ce,
  output logic          lcd_de,
  output logic          lcd_hsync,
  output logic          lcd_vsync,
  output logic [4:0]    lcd_r,
  output logic [5:0]    lcd_g,
  output logic [4:0]    lcd_b,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BW  = H_ACTIVE / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_GM   = HW'((1 << GRID_LOG2) - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_GM   = VW'((1 << GRID_LOG2) - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BW - 1);

  logic [DW-1:0]  div_cnt, div_nxt;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [BCW-1:0] bar_cnt;
  logic [2:0]     bar_idx;
  logic [1:0]     mode_q, cur_mode;
  logic           in_act, hs_act, vs_act, origin, grid_on;
  logic [15:0]    rgb_nxt;

  // next divider value; parks at 0 while disabled
  always_comb begin
    div_nxt = '0;
    if (en && div_cnt != D_LAST) div_nxt = div_cnt + DW'(1);
  end

  // pixel clock-enable divider; strobe coincides with the last divider count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_ce  <= en && (div_nxt == D_LAST);
    end
  end

  // raster position: h wraps into v, v wraps at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // colour-bar run counter tracking h_cnt, avoids dividing x by bar width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!en) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == B_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + BCW'(1);
      end
    end
  end

  // region decode and pattern colour for the current raster position
  always_comb begin
    in_act   = (h_cnt < H_DE) && (v_cnt < V_DE);
    hs_act   = (h_cnt >= H_SS) && (h_cnt < H_SE);
    vs_act   = (v_cnt >= V_SS) && (v_cnt < V_SE);
    origin   = (h_cnt == '0) && (v_cnt == '0);
    cur_mode = origin ? mode : mode_q;
    grid_on  = ((h_cnt & H_GM) == '0) || ((v_cnt & V_GM) == '0);
    rgb_nxt  = '0;
    if (in_act) begin
      case (cur_mode)
        2'd0: rgb_nxt = {{5{~bar_idx[1]}},
                         {6{~bar_idx[2]}},
                         {5{~bar_idx[0]}}};
        2'd1: rgb_nxt = grid_on ? 16'hFFFF : 16'h0000;
        2'd2: rgb_nxt = {5'(h_cnt), 6'(v_cnt),
                         frame_cnt[4:0] + {4'd0, origin}};
        default: rgb_nxt = solid_rgb;
      endcase
    end
  end

  // registered LCD outputs, updated once per pixel; frame_start is 1 clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= ~HS_POL;
      lcd_vsync   <= ~VS_POL;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      mode_q      <= '0;
    end else if (!en) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= ~HS_POL;
      lcd_vsync   <= ~VS_POL;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && origin;
      if (pix_ce) begin
        lcd_de    <= in_act;
        lcd_hsync <= hs_act ? HS_POL : ~HS_POL;
        lcd_vsync <= vs_act ? VS_POL : ~VS_POL;
        lcd_r     <= rgb_nxt[15:11];
        lcd_g     <= rgb_nxt[10:5];
        lcd_b     <= rgb_nxt[4:0];
        pix_x     <= in_act ? h_cnt[XW-1:0] : '0;
        pix_y     <= in_act ? v_cnt[YW-1:0] : '0;
        if (origin) begin
          frame_cnt <= frame_cnt + 16'd1;
          mode_q    <= mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Scoreboard bench for lcd_timing_pattern_gen: pixel-index reference
// model feeds a queue, a monitor pops on each DUT pixel update.
`timescale 1ns/1ps
module tb_lcd_timing_pattern_gen;

  localparam int HA = 16, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 8,  VFP = 1, VSW = 1, VBP = 1;
  localparam int PD = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int GL = 4;

  typedef struct packed {
    logic de, hs, vs;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [3:0] x;
    logic [2:0] y;
    logic fs;
    logic [15:0] fc;
  } px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] solid = 16'h0;
  logic pix_ce, de, hs, vs, fs;
  logic [4:0] r, b;
  logic [5:0] g;
  logic [3:0] px;
  logic [2:0] py;
  logic [15:0] fc;

  logic rst1 = 1'b0;
  logic en1 = 1'b1;
  logic [1:0] mode1 = 2'd3;
  logic [15:0] solid1 = 16'hF800;
  logic ce1, de1, hs1, vs1, fs1;
  logic [4:0] r1, b1;
  logic [5:0] g1;
  logic [3:0] px1;
  logic [2:0] py1;
  logic [15:0] fc1;

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_DIV(PD), .HS_POL(HSP), .VS_POL(VSP), .GRID_LOG2(GL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .solid_rgb(solid), .pix_ce(pix_ce), .lcd_de(de),
    .lcd_hsync(hs), .lcd_vsync(vs), .lcd_r(r), .lcd_g(g),
    .lcd_b(b), .pix_x(px), .pix_y(py),
    .frame_start(fs), .frame_cnt(fc)
  );

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_DIV(1), .HS_POL(HSP), .VS_POL(VSP), .GRID_LOG2(GL)
  ) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1),
    .solid_rgb(solid1), .pix_ce(ce1), .lcd_de(de1),
    .lcd_hsync(hs1), .lcd_vsync(vs1), .lcd_r(r1),
    .lcd_g(g1), .lcd_b(b1), .pix_x(px1), .pix_y(py1),
    .frame_start(fs1), .frame_cnt(fc1)
  );

  int checks = 0, failures = 0;
  px_t q[$];
  int clk_run = 0, pix = 0, frames = 0, lmode = 0;
  bit exp_ce = 1'b0, exp_fs = 1'b0;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] bar_colour(int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic px_t ref_px(int p, int fr, int m,
                                 logic [15:0] s);
    px_t e;
    int h, v;
    logic [15:0] c;
    h = p % HT;
    v = p / HT;
    c = 16'h0;
    e.de = (h < HA) && (v < VA);
    e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : !HSP;
    e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VSP : !VSP;
    e.x  = e.de ? 4'(h) : 4'd0;
    e.y  = e.de ? 3'(v) : 3'd0;
    e.fs = (p == 0);
    e.fc = 16'(fr);
    if (e.de) begin
      case (m)
        0: c = bar_colour(h / (HA / 8));
        1: c = (h % (1 << GL) == 0 || v % (1 << GL) == 0)
               ? 16'hFFFF : 16'h0000;
        2: c = {5'(h % 32), 6'(v % 64), 5'(fr % 32)};
        default: c = s;
      endcase
    end
    e.r = c[15:11];
    e.g = c[10:5];
    e.b = c[4:0];
    return e;
  endfunction

  // reference model: pixel k after enable lands on clock k*PD
  initial begin
    forever begin
      @(posedge clk);
      exp_fs = 1'b0;
      if (!rst) begin
        clk_run = 0; pix = 0; frames = 0; lmode = 0;
        exp_ce = 1'b0;
      end else if (!en) begin
        clk_run = 0; pix = 0;
        exp_ce = 1'b0;
      end else begin
        clk_run++;
        if (clk_run % PD == 0) begin
          if (pix == 0) begin
            frames = (frames + 1) % 65536;
            lmode = int'(mode);
            exp_fs = 1'b1;
          end
          q.push_back(ref_px(pix, frames, lmode, solid));
          pix = (pix + 1) % FR;
        end
        exp_ce = ((clk_run + 1) % PD == 0);
      end
    end
  end

  // monitor: compare whenever the DUT has just taken a pixel step
  initial begin
    bit prev_ce;
    px_t got, e;
    prev_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_ce && en && rst) begin
        got.de = de; got.hs = hs; got.vs = vs;
        got.r = r; got.g = g; got.b = b;
        got.x = px; got.y = py; got.fs = fs; got.fc = fc;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty got=%h exp=none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL pixel got=%h exp=%h", got, e);
          end
        end
      end
      chk("pix_ce", 32'(pix_ce), 32'(exp_ce));
      chk("frame_start", 32'(fs), 32'(exp_fs));
      prev_ce = pix_ce;
    end
  end

  // PIX_DIV=1 instance: ce stuck high, solid red in active area
  initial begin
    int nfs, nde;
    nfs = 0; nde = 0;
    @(posedge rst1);
    for (int i = 0; i < FR; i++) begin
      @(posedge clk);
      #1;
      chk("ce1_stuck", 32'(ce1), 32'd1);
      if (de1) begin
        chk("solid_rgb", {16'd0, r1, g1, b1}, 32'h0000F800);
        nde++;
      end else begin
        chk("blank_rgb", {16'd0, r1, g1, b1}, 32'h0);
      end
      if (fs1) nfs++;
    end
    chk("de1_count", 32'(nde), 32'(HA * VA));
    chk("fs1_count", 32'(nfs), 32'd1);
  end

  task automatic run(int n, bit rnd);
    repeat (n) begin
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(0, 39) == 0)
          mode = 2'($urandom_range(0, 3));
        solid = 16'($urandom);
      end
    end
  endtask

  task automatic chk_idle(string tag, logic [15:0] efc,
                          logic ece);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_hsync"}, 32'(hs), 32'(!HSP));
    chk({tag, "_vsync"}, 32'(vs), 32'(!VSP));
    chk({tag, "_rgb"}, {16'd0, r, g, b}, 32'd0);
    chk({tag, "_xy"}, {25'd0, px, py}, 32'd0);
    chk({tag, "_fs"}, 32'(fs), 32'd0);
    chk({tag, "_fcnt"}, 32'(fc), 32'(efc));
    chk({tag, "_ce"}, 32'(pix_ce), 32'(ece));
  endtask

  initial begin
    run(3, 1'b0);
    chk_idle("reset", 16'h0, 1'b0);
    rst = 1'b1; en = 1'b1; mode = 2'd0;
    rst1 = 1'b1;
    run(FR * PD, 1'b0);
    mode = 2'd1;
    run(FR * PD / 2, 1'b0);
    mode = 2'd2;
    run(FR * PD, 1'b0);
    run(FR * PD * 2, 1'b1);
    run(PD * 30, 1'b1);
    en = 1'b0;
    run(5, 1'b0);
    chk_idle("en_low", 16'(frames), 1'b0);
    en = 1'b1;
    run(FR * PD, 1'b1);
    en = 1'b0;
    run(2, 1'b0);
    force dut.frame_cnt = 16'hFFFE;
    frames = 16'hFFFE;
    run(1, 1'b0);
    release dut.frame_cnt;
    run(1, 1'b0);
    chk("fcnt_preset", 32'(fc), 32'h0000FFFE);
    mode = 2'd2;
    en = 1'b1;
    run(FR * PD * 2 + 10, 1'b0);
    en = 1'b0;
    run(1, 1'b0);
    en = 1'b1;
    run(PD * (HT * 2 + 5), 1'b1);
    chk("pre_rst_de", 32'(de), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle("async_rst", 16'h0, 1'b0);
    run(2, 1'b0);
    rst = 1'b1;
    run(FR * PD, 1'b1);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
